// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// The request/response structs mirror the core's ibus/dbus typedefs for downstream users.
package mem_bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 64;
    localparam int BUS_DATA_W = 64;

    localparam logic [2:0] FETCH_SIZE = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic                    valid;
        logic                    is_fetch;
        logic [BUS_ADDR_W-1:0]   addr;
        logic [2:0]              size;
        logic [BUS_DATA_W/8-1:0] strobe;
        logic [BUS_DATA_W-1:0]   data;
    } mreq_t;

    typedef struct packed {
        logic                  addr_ok;
        logic                  data_ok;
        logic [BUS_DATA_W-1:0] data;
    } mresp_t;

    // Instruction words are 32 bits; addr[2] picks the half of the 64-bit beat.
    function automatic logic [31:0] select_word(input logic [63:0] beat, input logic upper);
        return upper ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around the arbiter.
// master = the arbiter's view; slave = the surrounding core and memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    logic                ireq_valid;
    logic [ADDR_W-1:0]   ireq_addr;
    logic                iresp_addr_ok;
    logic                iresp_data_ok;
    logic [31:0]         iresp_data;

    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [2:0]          dreq_size;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic [DATA_W-1:0]   dreq_data;
    logic                dresp_addr_ok;
    logic                dresp_data_ok;
    logic [DATA_W-1:0]   dresp_data;

    logic                mreq_valid;
    logic                mreq_is_fetch;
    logic [ADDR_W-1:0]   mreq_addr;
    logic [2:0]          mreq_size;
    logic [DATA_W/8-1:0] mreq_strobe;
    logic [DATA_W-1:0]   mreq_data;
    logic                mresp_addr_ok;
    logic                mresp_data_ok;
    logic [DATA_W-1:0]   mresp_data;

    modport master (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output mreq_valid, mreq_is_fetch, mreq_addr, mreq_size, mreq_strobe, mreq_data,
        input  mresp_addr_ok, mresp_data_ok, mresp_data
    );

    modport slave (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  mreq_valid, mreq_is_fetch, mreq_addr, mreq_size, mreq_strobe, mreq_data,
        output mresp_addr_ok, mresp_data_ok, mresp_data
    );

endinterface

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// Saturating count of data grants made while a fetch was left waiting.
// Clear wins over increment so an instruction grant always restarts the count.
module arb_starve_ctr #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == W'(MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and data buses onto one downstream memory port, one transaction
// at a time. Data wins ties unless the fetch side has been starved STARVE_MAX times.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = BUS_ADDR_W,
    parameter int DATA_W     = BUS_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.master  bus
);

    arb_state_t state;
    arb_state_t state_next;

    logic grant_i;
    logic grant_d;
    logic starve_at_max;

    logic                req_is_fetch;
    logic [ADDR_W-1:0]   req_addr;
    logic [2:0]          req_size;
    logic [DATA_W/8-1:0] req_strobe;
    logic [DATA_W-1:0]   req_data;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_d && bus.ireq_valid),
        .clr    (grant_i),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A same-cycle addr_ok/data_ok pair skips the WAIT state entirely.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.dreq_valid && !(bus.ireq_valid && starve_at_max)) begin
                    state_next = GRANT_D;
                    grant_d    = 1'b1;
                end else if (bus.ireq_valid) begin
                    state_next = GRANT_I;
                    grant_i    = 1'b1;
                end
            end
            GRANT_I: begin
                if (bus.mresp_addr_ok) begin
                    state_next = bus.mresp_data_ok ? IDLE : WAIT_I;
                end
            end
            GRANT_D: begin
                if (bus.mresp_addr_ok) begin
                    state_next = bus.mresp_data_ok ? IDLE : WAIT_D;
                end
            end
            WAIT_I: begin
                if (bus.mresp_data_ok) begin
                    state_next = IDLE;
                end
            end
            WAIT_D: begin
                if (bus.mresp_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured only at grant, so downstream sees them stable
    // for the whole transaction even if the requester changes its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_is_fetch <= 1'b0;
            req_addr     <= '0;
            req_size     <= '0;
            req_strobe   <= '0;
            req_data     <= '0;
        end else if (grant_d) begin
            req_is_fetch <= 1'b0;
            req_addr     <= bus.dreq_addr;
            req_size     <= bus.dreq_size;
            req_strobe   <= bus.dreq_strobe;
            req_data     <= bus.dreq_data;
        end else if (grant_i) begin
            req_is_fetch <= 1'b1;
            req_addr     <= bus.ireq_addr;
            req_size     <= FETCH_SIZE;
            req_strobe   <= '0;
            req_data     <= '0;
        end
    end

    assign bus.mreq_valid    = (state == GRANT_I) || (state == GRANT_D);
    assign bus.mreq_is_fetch = req_is_fetch;
    assign bus.mreq_addr     = req_addr;
    assign bus.mreq_size     = req_size;
    assign bus.mreq_strobe   = req_strobe;
    assign bus.mreq_data     = req_data;

    // Responses are suppressed during reset so an aborted transaction never completes.
    assign bus.iresp_addr_ok = !reset && (state == GRANT_I) && bus.mresp_addr_ok;
    assign bus.dresp_addr_ok = !reset && (state == GRANT_D) && bus.mresp_addr_ok;

    assign bus.iresp_data_ok = !reset && bus.mresp_data_ok &&
                               (((state == GRANT_I) && bus.mresp_addr_ok) || (state == WAIT_I));
    assign bus.dresp_data_ok = !reset && bus.mresp_data_ok &&
                               (((state == GRANT_D) && bus.mresp_addr_ok) || (state == WAIT_D));

    assign bus.iresp_data = select_word(bus.mresp_data[63:0], req_addr[2]);
    assign bus.dresp_data = bus.mresp_data;

endmodule
